dwconv_pad_feeder: RTL and testbench

- Feeds the depthwise-conv window generator: reads one 8-bit feature-map channel from on-chip RAM in raster order and adds a zero-padding border.
- Emits one pixel per cycle as a 1-cycle-per-pixel stream, in the exact format the window generator consumes (data_in, no back-pressure).
- Sits between the feature-map DRM buffer and the window generator; the conv controller starts it once per channel plane.

---
 rtl/dwconv_pkg.sv | 22 ++
 rtl/dwconv_lat_pipe.sv | 30 +++
 rtl/dwconv_pad_feeder.sv | 153 +++++++++++++++
 tb/tb_dwconv_pad_feeder.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dwconv_pkg.sv
// Shared depthwise-conv definitions: feeder FSM states, default border value
// and the tag layout that travels alongside each RAM read.
package dwconv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } feed_state_e;

  localparam logic [7:0] PAD_VAL_DEFAULT = 8'd0;

  typedef struct packed {
    logic valid;
    logic pad;
    logic first;
    logic last;
  } pix_tag_t;

  localparam int unsigned TAG_W = $bits(pix_tag_t);

endpackage

// File: rtl/dwconv_lat_pipe.sv
// Fixed-depth shift register that delays per-pixel tag bits so they line up
// with RAM read data arriving DEPTH cycles after the request.
module dwconv_lat_pipe #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/dwconv_pad_feeder.sv
// Streams one feature-map channel from RAM in raster order with a one-pixel
// PAD_VAL border. Optional `hold` input enabled by macro DWCONV_FEED_HOLD_EN.
module dwconv_pad_feeder
  import dwconv_pkg::*;
#(
  parameter int unsigned IMG_W   = 32,
  parameter int unsigned IMG_H   = 32,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned RD_LAT  = 2,
  parameter logic [7:0]  PAD_VAL = PAD_VAL_DEFAULT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
`ifdef DWCONV_FEED_HOLD_EN
  input  logic              hold,
`endif
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [7:0]        data_out,
  output logic              data_valid,
  output logic              row_first,
  output logic              frame_last
);

  localparam int unsigned PW = IMG_W + 2;
  localparam int unsigned PH = IMG_H + 2;
  localparam int unsigned CW = $clog2(PW);
  localparam int unsigned RW = $clog2(PH);

  feed_state_e       state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [ADDR_W-1:0] nxt_addr_q, nxt_addr_d;
  logic [ADDR_W-1:0] rd_addr_q;

  logic [7:0] data_out_q;
  logic       data_valid_q, row_first_q, frame_last_q, done_q;

  logic     hold_act;
  logic     issue, row_int, col_int, last_px;
  pix_tag_t tag_in, tag_out;

`ifdef DWCONV_FEED_HOLD_EN
  assign hold_act = hold;
`else
  assign hold_act = 1'b0;
`endif

  assign row_int = (row_q != '0) && (row_q <= RW'(IMG_H));
  assign col_int = (col_q != '0) && (col_q <= CW'(IMG_W));
  assign last_px = (row_q == RW'(PH - 1)) && (col_q == CW'(PW - 1));

  // Pixel (0,0) is always border, so it is tagged in the start cycle itself;
  // this keeps the first output RD_LAT+1 cycles after start while the RAM
  // data path keeps its full read latency plus the registered output stage.
  assign issue = ((state_q == ST_IDLE) && start) ||
                 ((state_q == ST_ISSUE) && !hold_act);

  assign rd_en   = issue && (state_q == ST_ISSUE) && row_int && col_int;
  assign rd_addr = rd_en ? nxt_addr_q : rd_addr_q;

  always_comb begin
    tag_in = '0;
    if (issue) begin
      tag_in.valid = 1'b1;
      tag_in.pad   = !(row_int && col_int);
      tag_in.first = (col_q == '0);
      tag_in.last  = last_px;
    end
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    nxt_addr_d = nxt_addr_q;

    if (issue) begin
      if (col_q == CW'(PW - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(PH - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      if (last_px) begin
        nxt_addr_d = '0;
      end else if (rd_en) begin
        nxt_addr_d = nxt_addr_q + ADDR_W'(1);
      end
    end

    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_ISSUE;
      ST_ISSUE: if (issue && last_px) state_d = ST_DRAIN;
      ST_DRAIN: if (done_q) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      nxt_addr_q <= '0;
      rd_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      nxt_addr_q <= nxt_addr_d;
      rd_addr_q  <= rd_addr;
    end
  end

  dwconv_lat_pipe #(
    .DEPTH(RD_LAT),
    .WIDTH(TAG_W)
  ) u_lat_pipe (
    .clk_i (clk),
    .rst_ni(rstn),
    .d_i   (tag_in),
    .q_o   (tag_out)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      row_first_q  <= 1'b0;
      frame_last_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      data_out_q   <= !tag_out.valid ? 8'd0 : (tag_out.pad ? PAD_VAL : rd_data);
      data_valid_q <= tag_out.valid;
      row_first_q  <= tag_out.valid && tag_out.first;
      frame_last_q <= tag_out.valid && tag_out.last;
      done_q       <= tag_out.valid && tag_out.last;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign row_first  = row_first_q;
  assign frame_last = frame_last_q;

endmodule

// File: tb/tb_dwconv_pad_feeder.sv
// Scoreboard bench for dwconv_pad_feeder: a 4x3/RD_LAT=2 instance and a
// 1x1/RD_LAT=1 instance, each with its own latency-accurate RAM model.
`timescale 1ns/1ps
module tb_dwconv_pad_feeder;

  localparam int NI = 2;
  localparam int AW = 10;

  function automatic int cfg_w(int g);   return (g == 0) ? 4 : 1; endfunction
  function automatic int cfg_h(int g);   return (g == 0) ? 3 : 1; endfunction
  function automatic int cfg_lat(int g); return (g == 0) ? 2 : 1; endfunction

  typedef struct {
    logic [7:0] data;
    logic       first;
    logic       last;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rstn       [NI];
  logic          start      [NI];
`ifdef DWCONV_FEED_HOLD_EN
  logic          hold       [NI];
`endif
  logic          busy       [NI];
  logic          done       [NI];
  logic          rd_en      [NI];
  logic [AW-1:0] rd_addr    [NI];
  logic [7:0]    rd_data    [NI];
  logic [7:0]    data_out   [NI];
  logic          data_valid [NI];
  logic          row_first  [NI];
  logic          frame_last [NI];

  logic [7:0] mem [NI][16];
  exp_t       expq  [NI][$];
  int         addrq [NI][$];
  int         pix_cnt   [NI];
  bit         done_seen [NI];

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, int g, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s[inst %0d] @cycle %0d: got 0x%0h, required 0x%0h", name, g, cyc, act, req);
    end
  endfunction

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int unsigned GW = (g == 0) ? 4 : 1;
    localparam int unsigned GH = (g == 0) ? 3 : 1;
    localparam int unsigned GL = (g == 0) ? 2 : 1;

    dwconv_pad_feeder #(
      .IMG_W  (GW),
      .IMG_H  (GH),
      .ADDR_W (AW),
      .RD_LAT (GL),
      .PAD_VAL(8'd0)
    ) u_dut (
      .clk       (clk),
      .rstn      (rstn[g]),
      .start     (start[g]),
`ifdef DWCONV_FEED_HOLD_EN
      .hold      (hold[g]),
`endif
      .busy      (busy[g]),
      .done      (done[g]),
      .rd_en     (rd_en[g]),
      .rd_addr   (rd_addr[g]),
      .rd_data   (rd_data[g]),
      .data_out  (data_out[g]),
      .data_valid(data_valid[g]),
      .row_first (row_first[g]),
      .frame_last(frame_last[g])
    );

    // RAM: data for a read in cycle t is visible in cycle t+GL; garbage otherwise.
    logic [7:0] rp [GL];
    always @(posedge clk) begin
      rp[0] <= rd_en[g] ? mem[g][rd_addr[g][3:0]] : 8'hEE;
      for (int i = 1; i < GL; i++) rp[i] <= rp[i-1];
    end
    assign rd_data[g] = rp[GL-1];

    exp_t e;
    int   a;
    bit   done_prev = 1'b0;
    always @(negedge clk) begin
      if (!rstn[g]) begin
        chk("reset_outputs", g,
            {busy[g], done[g], rd_en[g], data_valid[g], row_first[g], frame_last[g],
             data_out[g], rd_addr[g]}, 0);
      end else begin
        if (rd_en[g]) begin
          if (addrq[g].size() == 0) begin
            checks++; errors++;
            $display("FAIL extra_read[inst %0d] @cycle %0d: got read at 0x%0h, required no read", g, cyc, rd_addr[g]);
          end else begin
            a = addrq[g].pop_front();
            chk("rd_addr", g, rd_addr[g], a);
          end
        end
        if (data_valid[g]) begin
          pix_cnt[g]++;
          if (expq[g].size() == 0) begin
            checks++; errors++;
            $display("FAIL extra_pixel[inst %0d] @cycle %0d: got 0x%0h, required no pixel", g, cyc, data_out[g]);
          end else begin
            e = expq[g].pop_front();
            chk("data_out",     g, data_out[g],   e.data);
            chk("row_first",    g, row_first[g],  e.first);
            chk("frame_last",   g, frame_last[g], e.last);
            chk("pixel_cycle",  g, cyc,           e.cyc);
            chk("done_vs_last", g, done[g],       e.last);
          end
        end else begin
          chk("done_no_pixel", g, done[g], 0);
        end
        if (done_prev) chk("busy_after_done", g, busy[g], 0);
        if (done[g]) begin
          done_seen[g] = 1'b1;
          chk("busy_at_done", g, busy[g], 1);
        end
      end
      done_prev = done[g] && rstn[g];
    end
  end

  // Reference: pixel k is issued at the k-th non-held cycle after start
  // (pixel 0 in the start cycle) and shows up RD_LAT+1 cycles later.
  function automatic void model_frame(int g, int s, int hf, int hl);
    int w  = cfg_w(g);
    int h  = cfg_h(g);
    int pw = w + 2;
    int ph = h + 2;
    int t  = s;
    exp_t e;
    for (int r = 0; r < ph; r++) begin
      for (int c = 0; c < pw; c++) begin
        bit border = (r == 0) || (r == ph - 1) || (c == 0) || (c == pw - 1);
        if (r != 0 || c != 0) begin
          t++;
          while (hl > 0 && t >= s + hf && t < s + hf + hl) t++;
        end
        e.data  = border ? 8'h00 : mem[g][(r-1)*w + (c-1)];
        e.first = (c == 0);
        e.last  = (r == ph - 1) && (c == pw - 1);
        e.cyc   = t + cfg_lat(g) + 1;
        expq[g].push_back(e);
        if (!border) addrq[g].push_back((r-1)*w + (c-1));
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ram(int g, bit incr);
    for (int i = 0; i < 16; i++) mem[g][i] = incr ? 8'(i + 1) : 8'($urandom_range(0, 255));
  endtask

  task automatic issue_frame(input int g, input int hf, input int hl, output int s);
    step();
    s = cyc;
    model_frame(g, s, hf, hl);
    pix_cnt[g]   = 0;
    done_seen[g] = 1'b0;
    start[g]     = 1'b1;
    step();
    start[g] = 1'b0;
    chk("busy_after_start", g, busy[g], 1);
`ifdef DWCONV_FEED_HOLD_EN
    if (hl > 0) begin
      while (cyc < s + hf + hl) begin
        hold[g] = (cyc >= s + hf);
        step();
      end
      hold[g] = 1'b0;
    end
`endif
  endtask

  task automatic wait_done(int g, int budget);
    int n = 0;
    while (!done_seen[g] && n < budget) begin
      step();
      n++;
    end
    if (!done_seen[g]) begin
      checks++; errors++;
      $display("FAIL done_timeout[inst %0d]: got no done within %0d cycles, required done", g, budget);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("pixels_left", g, expq[g].size(), 0);
    chk("reads_left",  g, addrq[g].size(), 0);
    chk("pixel_count", g, pix_cnt[g], (cfg_w(g) + 2) * (cfg_h(g) + 2));
    chk("busy_idle",   g, busy[g], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    int dc;
    int n;
    for (int g = 0; g < NI; g++) begin
      rstn[g] = 1'b1; start[g] = 1'b0;
`ifdef DWCONV_FEED_HOLD_EN
      hold[g] = 1'b0;
`endif
      pix_cnt[g] = 0; done_seen[g] = 1'b0;
    end
    #2;
    for (int g = 0; g < NI; g++) rstn[g] = 1'b0;
    repeat (3) step();
    for (int g = 0; g < NI; g++) rstn[g] = 1'b1;
    step();
    for (int g = 0; g < NI; g++) chk("idle_busy", g, busy[g], 0);

    // 4x3 frame with RAM[i]=i+1, then 1x1 frame with a single 0xA5 pixel
    load_ram(0, 1'b1);
    issue_frame(0, 0, 0, s);
    wait_done(0, 100);
    load_ram(1, 1'b0);
    mem[1][0] = 8'hA5;
    issue_frame(1, 0, 0, s);
    wait_done(1, 50);

    // start while busy and in the done cycle is ignored; a later start repeats the frame
    load_ram(0, 1'b0);
    issue_frame(0, 0, 0, s);
    while (cyc < s + 10) step();
    start[0] = 1'b1; step(); start[0] = 1'b0;
    dc = s + cfg_lat(0) + 1 + 6 * 5 - 1;
    while (cyc < dc) step();
    start[0] = 1'b1; step(); start[0] = 1'b0;
    wait_done(0, 100);
    repeat (10) step();
    chk("no_second_frame", 0, pix_cnt[0], 30);
    issue_frame(0, 0, 0, s);
    wait_done(0, 100);

    // reset at the 10th pixel, then a fresh frame
    load_ram(0, 1'b0);
    issue_frame(0, 0, 0, s);
    n = 0;
    while (pix_cnt[0] < 10 && n < 100) begin step(); n++; end
    chk("reached_10th_pixel", 0, pix_cnt[0] >= 10, 1);
    rstn[0] = 1'b0;
    expq[0].delete();
    addrq[0].delete();
    repeat (3) step();
    chk("no_partial_done", 0, done_seen[0], 0);
    rstn[0] = 1'b1;
    step();
    load_ram(0, 1'b0);
    issue_frame(0, 0, 0, s);
    wait_done(0, 100);

    // randomized frames on both instances
    for (int k = 0; k < 4; k++) begin
      int g = int'($urandom_range(0, 1));
      load_ram(g, 1'b0);
      repeat ($urandom_range(0, 3)) step();
      issue_frame(g, 0, 0, s);
      wait_done(g, 100);
    end

`ifdef DWCONV_FEED_HOLD_EN
    load_ram(0, 1'b1);
    issue_frame(0, 5, 3, s);
    wait_done(0, 100);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
